vga_fb_scheduler: RTL and testbench

Schedules the single shared frame-buffer memory port between the camera write path and the VGA line-prefetch read path, and manages double-buffered frame banks. It sits between the pixel FIFOs and the memory controller. The VGA timing generator's request and frame-done outputs drive the read side; the camera capture path drives the write side. The scheduler issues fixed-length burst commands with generated addresses and swaps the read and write banks only at a VGA frame boundary.

---
 rtl/vga_fb_pkg.sv | 25 ++
 rtl/vga_fb_addr_cnt.sv | 41 ++++
 rtl/vga_fb_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_vga_fb_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_fb_pkg.sv
// Shared types and default geometry for the frame-buffer port scheduler.
package vga_fb_pkg;

  // Default memory geometry: 640x480 frame of words, 8-word bursts,
  // 22-bit word address whose MSB selects the frame bank.
  localparam int DEF_ADDR_W      = 22;
  localparam int DEF_BURST       = 8;
  localparam int DEF_FRAME_WORDS = 307200;

  // Scheduler FSM states
  //   IDLE | arbitrate; on a winner latch the command
  //   CMD  | command presented, waiting for memory controller accept
  //   BUSY | burst in flight, waiting for burst-done pulse
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    BUSY = 2'd2
  } fsm_state_e;

  // Offset counter width for a frame of the given word count.
  function automatic int off_width(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/vga_fb_addr_cnt.sv
// Frame offset counter: advances by STEP, wraps to zero at LIMIT,
// synchronous clear has priority over the step.
module vga_fb_addr_cnt #(
  parameter int WIDTH = 19,
  parameter int LIMIT = 307200,
  parameter int STEP  = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] off_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST   = WIDTH'(LIMIT - STEP);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] off_q, off_d;

  // wrap flags the step that takes the counter from the last burst back to 0
  assign wrap_o = step_i & (off_q == LAST);
  assign off_o  = off_q;

  // next offset: clear wins, otherwise step with wrap at LIMIT
  always_comb begin
    off_d = off_q;
    if (clr_i) begin
      off_d = '0;
    end else if (step_i) begin
      off_d = (off_q == LAST) ? '0 : off_q + STEP_W;
    end
  end

  // offset register
  always_ff @(posedge clk_i) begin
    if (rst_i) off_q <= '0;
    else       off_q <= off_d;
  end

endmodule

// File: rtl/vga_fb_scheduler.sv
// Arbitrates the single frame-buffer port between camera writes and VGA
// line-prefetch reads, issuing fixed-length bursts, and swaps the
// double-buffered frame banks only on a VGA frame boundary.
module vga_fb_scheduler
  import vga_fb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BURST       = DEF_BURST,
  parameter int FRAME_WORDS = DEF_FRAME_WORDS
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iRd_Req,
  input  logic              iRd_Urgent,
  input  logic              iWr_Req,
  input  logic              iVga_FrameDone,
  input  logic              iCam_FrameDone,
  output logic              oCmd_Valid,
  output logic              oCmd_Write,
  output logic [ADDR_W-1:0] oCmd_Addr,
  input  logic              iCmd_Ready,
  input  logic              iBurst_Done,
  output logic              oRd_Grant,
  output logic              oWr_Grant,
  output logic              oRd_Bank,
  output logic              oWr_Stall
);

  localparam int OFF_W = off_width(FRAME_WORDS);

  fsm_state_e        state_q;
  logic              cmd_valid_q;
  logic              cmd_write_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic              last_wr_q;

  logic              rd_bank_q;
  logic              wr_bank_q;
  logic              swap_pending_q;
  logic              vga_edge_q;

  logic [OFF_W-1:0]  rd_off;
  logic [OFF_W-1:0]  wr_off;
  logic              rd_wrap;
  logic              wr_wrap;
  logic              unused_wrap;

  logic              elig_rd;
  logic              elig_wr;
  logic              pick_rd;
  logic              pick_wr;
  logic              accept;
  logic              rd_grant;
  logic              wr_grant;
  logic              swap;
  logic              rd_bank_next;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;

  // The wrap flags are informational; offsets wrap inside the counters.
  assign unused_wrap = rd_wrap ^ wr_wrap;

  assign elig_rd = iRd_Req;
  assign elig_wr = iWr_Req & ~swap_pending_q;

  assign accept   = (state_q == CMD) & iCmd_Ready;
  assign rd_grant = accept & ~cmd_write_q;
  assign wr_grant = accept &  cmd_write_q;

  assign swap = swap_pending_q & (state_q == IDLE) & vga_edge_q;

  // A read latched in the swap cycle must already target the new display bank.
  assign rd_bank_next = swap ? wr_bank_q : rd_bank_q;
  assign rd_addr      = {rd_bank_next, (ADDR_W-1)'(rd_off)};
  assign wr_addr      = {wr_bank_q,    (ADDR_W-1)'(wr_off)};

  // Priority: urgent read, then round-robin on a tie, then whichever is alone.
  always_comb begin
    pick_rd = 1'b0;
    pick_wr = 1'b0;
    if (elig_rd && iRd_Urgent) begin
      pick_rd = 1'b1;
    end else if (elig_rd && elig_wr) begin
      if (last_wr_q) pick_rd = 1'b1;
      else           pick_wr = 1'b1;
    end else if (elig_wr) begin
      pick_wr = 1'b1;
    end else if (elig_rd) begin
      pick_rd = 1'b1;
    end
  end

  vga_fb_addr_cnt #(
    .WIDTH (OFF_W),
    .LIMIT (FRAME_WORDS),
    .STEP  (BURST)
  ) u_rd_cnt (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .clr_i  (iVga_FrameDone),
    .step_i (rd_grant),
    .off_o  (rd_off),
    .wrap_o (rd_wrap)
  );

  vga_fb_addr_cnt #(
    .WIDTH (OFF_W),
    .LIMIT (FRAME_WORDS),
    .STEP  (BURST)
  ) u_wr_cnt (
    .clk_i  (iCLK),
    .rst_i  (iRST),
    .clr_i  (iCam_FrameDone),
    .step_i (wr_grant),
    .off_o  (wr_off),
    .wrap_o (wr_wrap)
  );

  // Command FSM with registered command outputs; last_wr_q starts at 1 so
  // the first tie goes to the read side.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      last_wr_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_rd || pick_wr) begin
            state_q     <= CMD;
            cmd_valid_q <= 1'b1;
            cmd_write_q <= pick_wr;
            cmd_addr_q  <= pick_wr ? wr_addr : rd_addr;
          end
        end
        CMD: begin
          if (iCmd_Ready) begin
            state_q     <= BUSY;
            cmd_valid_q <= 1'b0;
            last_wr_q   <= cmd_write_q;
          end
        end
        BUSY: begin
          if (iBurst_Done) state_q <= IDLE;
        end
        default: begin
          state_q     <= IDLE;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Bank ownership and swap handshake. A VGA frame-done only counts once a
  // camera frame is complete, so a coincident pair waits one more VGA frame.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      rd_bank_q      <= 1'b0;
      wr_bank_q      <= 1'b1;
      swap_pending_q <= 1'b0;
      vga_edge_q     <= 1'b0;
    end else begin
      if (swap) begin
        rd_bank_q <= wr_bank_q;
        wr_bank_q <= ~wr_bank_q;
      end

      if (iCam_FrameDone)  swap_pending_q <= 1'b1;
      else if (swap)       swap_pending_q <= 1'b0;

      if (!swap_pending_q || swap) vga_edge_q <= 1'b0;
      else if (iVga_FrameDone)     vga_edge_q <= 1'b1;
    end
  end

  assign oCmd_Valid = cmd_valid_q;
  assign oCmd_Write = cmd_write_q;
  assign oCmd_Addr  = cmd_addr_q;
  assign oRd_Grant  = rd_grant;
  assign oWr_Grant  = wr_grant;
  assign oRd_Bank   = rd_bank_q;
  assign oWr_Stall  = swap_pending_q;

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Directed bench for vga_fb_scheduler. The frame is shortened to 4800 words
// (600 bursts, deliberately not a power of two) so the offset wrap is
// reachable in a short run; the burst size and address width are the defaults.
module tb_vga_fb_scheduler;

  localparam int ADDR_W = 22;
  localparam int BURST  = 8;
  localparam int FW     = 4800;
  localparam logic [ADDR_W-1:0] BANK1 = 22'h200000;

  logic              iCLK = 1'b0;
  logic              iRST = 1'b1;
  logic              iRd_Req = 1'b0;
  logic              iRd_Urgent = 1'b0;
  logic              iWr_Req = 1'b0;
  logic              iVga_FrameDone = 1'b0;
  logic              iCam_FrameDone = 1'b0;
  logic              oCmd_Valid;
  logic              oCmd_Write;
  logic [ADDR_W-1:0] oCmd_Addr;
  logic              iCmd_Ready = 1'b1;
  logic              iBurst_Done = 1'b0;
  logic              oRd_Grant;
  logic              oWr_Grant;
  logic              oRd_Bank;
  logic              oWr_Stall;

  int vectors = 0;
  int miscompares = 0;

  vga_fb_scheduler #(
    .ADDR_W      (ADDR_W),
    .BURST       (BURST),
    .FRAME_WORDS (FW)
  ) dut (
    .iCLK           (iCLK),
    .iRST           (iRST),
    .iRd_Req        (iRd_Req),
    .iRd_Urgent     (iRd_Urgent),
    .iWr_Req        (iWr_Req),
    .iVga_FrameDone (iVga_FrameDone),
    .iCam_FrameDone (iCam_FrameDone),
    .oCmd_Valid     (oCmd_Valid),
    .oCmd_Write     (oCmd_Write),
    .oCmd_Addr      (oCmd_Addr),
    .iCmd_Ready     (iCmd_Ready),
    .iBurst_Done    (iBurst_Done),
    .oRd_Grant      (oRd_Grant),
    .oWr_Grant      (oWr_Grant),
    .oRd_Bank       (oRd_Bank),
    .oWr_Stall      (oWr_Stall)
  );

  always #5 iCLK = ~iCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    iRST = 1'b1;
    iRd_Req = 1'b0; iRd_Urgent = 1'b0; iWr_Req = 1'b0;
    iVga_FrameDone = 1'b0; iCam_FrameDone = 1'b0;
    iCmd_Ready = 1'b1; iBurst_Done = 1'b0;
    repeat (3) @(negedge iCLK);
    iRST = 1'b0;
  endtask

  // Wait (bounded) for a command, record it, then complete the burst `lat`
  // cycles after acceptance. With stop=1 all requests drop with the done pulse.
  task automatic do_burst(input int lat, input bit stop, output bit got, output int waits,
                          output logic wr, output logic [ADDR_W-1:0] addr,
                          output logic rg, output logic wg);
    got = 1'b0; waits = 0; wr = 1'b0; addr = '0; rg = 1'b0; wg = 1'b0;
    while (!got && waits < 40) begin
      @(negedge iCLK);
      waits++;
      if (oCmd_Valid === 1'b1) begin
        got = 1'b1; wr = oCmd_Write; addr = oCmd_Addr; rg = oRd_Grant; wg = oWr_Grant;
      end
    end
    if (got) begin
      repeat (lat) @(negedge iCLK);
      iBurst_Done = 1'b1;
      if (stop) begin iRd_Req = 1'b0; iWr_Req = 1'b0; iRd_Urgent = 1'b0; end
      @(negedge iCLK);
      iBurst_Done = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [ADDR_W+5:0] obs;
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge iCLK);
      obs = {oCmd_Valid, oCmd_Write, oRd_Grant, oWr_Grant, oRd_Bank, oWr_Stall, oCmd_Addr};
      vectors++;
      if (obs !== '0) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: outputs=%h required=0", i, obs);
      end
    end
  endtask

  task automatic test_read_only();
    bit got; int waits; logic wr, rg, wg; logic [ADDR_W-1:0] addr;
    apply_reset();
    iRd_Req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      do_burst(4, k == 3, got, waits, wr, addr, rg, wg);
      vectors++;
      if (got !== 1'b1) begin miscompares++; $display("FAIL rd_only_cmd %0d: no command seen", k); end
      if (k == 0) begin
        vectors++;
        if (waits !== 1) begin miscompares++; $display("FAIL rd_latency: got %0d cycles, required 1", waits); end
      end
      vectors++;
      if ({wr, rg, wg, addr} !== {1'b0, 1'b1, 1'b0, ADDR_W'(k * BURST)}) begin
        miscompares++;
        $display("FAIL rd_only_burst %0d: wr=%b rg=%b wg=%b addr=%h required wr=0 rg=1 wg=0 addr=%h",
                 k, wr, rg, wg, addr, ADDR_W'(k * BURST));
      end
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge iCLK);
      vectors++;
      if (oCmd_Valid !== 1'b0) begin miscompares++; $display("FAIL rd_only_quiet %0d: valid=%b required 0", i, oCmd_Valid); end
    end
  endtask

  task automatic test_arbitration();
    bit got; int waits; logic wr, rg, wg; logic [ADDR_W-1:0] addr;
    logic              exp_wr   [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [ADDR_W-1:0] exp_addr [8] = '{22'h000000, BANK1 | 22'h0, 22'h000008, BANK1 | 22'h8,
                                        22'h000010, 22'h000018, 22'h000020, BANK1 | 22'h10};
    apply_reset();
    iRd_Req = 1'b1; iWr_Req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 4) iRd_Urgent = 1'b1;
      if (k == 7) iRd_Urgent = 1'b0;
      do_burst(2, k == 7, got, waits, wr, addr, rg, wg);
      vectors++;
      if ({got, wr, addr, rg, wg} !== {1'b1, exp_wr[k], exp_addr[k], ~exp_wr[k], exp_wr[k]}) begin
        miscompares++;
        $display("FAIL arb_burst %0d: got=%b wr=%b addr=%h rg=%b wg=%b required wr=%b addr=%h",
                 k, got, wr, addr, rg, wg, exp_wr[k], exp_addr[k]);
      end
    end
  endtask

  task automatic test_cmd_hold();
    bit got; int waits; logic wr, rg, wg; logic [ADDR_W-1:0] addr;
    apply_reset();
    iCmd_Ready = 1'b0;
    iWr_Req = 1'b1;
    @(negedge iCLK);
    iWr_Req = 1'b0;
    iBurst_Done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if ({oCmd_Valid, oCmd_Write, oCmd_Addr, oWr_Grant, oRd_Grant} !== {1'b1, 1'b1, BANK1, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL cmd_hold %0d: valid=%b wr=%b addr=%h wg=%b rg=%b required 1 1 %h 0 0",
                 i, oCmd_Valid, oCmd_Write, oCmd_Addr, oWr_Grant, oRd_Grant, BANK1);
      end
      @(negedge iCLK);
      iBurst_Done = 1'b0;
    end
    iCmd_Ready = 1'b1;
    #1;
    vectors++;
    if ({oWr_Grant, oRd_Grant} !== 2'b10) begin
      miscompares++;
      $display("FAIL accept_grant: wg=%b rg=%b required wg=1 rg=0", oWr_Grant, oRd_Grant);
    end
    @(negedge iCLK);
    vectors++;
    if ({oCmd_Valid, oWr_Grant} !== 2'b00) begin
      miscompares++;
      $display("FAIL after_accept: valid=%b wg=%b required 0 0", oCmd_Valid, oWr_Grant);
    end
    iBurst_Done = 1'b1;
    @(negedge iCLK);
    iBurst_Done = 1'b0;
    iWr_Req = 1'b1;
    do_burst(1, 1'b1, got, waits, wr, addr, rg, wg);
    vectors++;
    if ({got, wr, addr} !== {1'b1, 1'b1, BANK1 | 22'h8}) begin
      miscompares++;
      $display("FAIL wr_advance: got=%b wr=%b addr=%h required wr=1 addr=%h", got, wr, addr, BANK1 | 22'h8);
    end
  endtask

  task automatic test_vga_clear_on_accept();
    bit got; int waits; logic wr, rg, wg; logic [ADDR_W-1:0] addr;
    apply_reset();
    iRd_Req = 1'b1;
    do_burst(1, 1'b0, got, waits, wr, addr, rg, wg);
    waits = 0;
    while (oCmd_Valid !== 1'b1 && waits < 20) begin @(negedge iCLK); waits++; end
    vectors++;
    if ({oCmd_Valid, oCmd_Addr} !== {1'b1, 22'h000008}) begin
      miscompares++;
      $display("FAIL vga_clr_pre: valid=%b addr=%h required 1 000008", oCmd_Valid, oCmd_Addr);
    end
    iVga_FrameDone = 1'b1;
    @(negedge iCLK);
    iVga_FrameDone = 1'b0;
    iBurst_Done = 1'b1;
    @(negedge iCLK);
    iBurst_Done = 1'b0;
    do_burst(1, 1'b1, got, waits, wr, addr, rg, wg);
    vectors++;
    if ({got, wr, addr} !== {1'b1, 1'b0, 22'h000000}) begin
      miscompares++;
      $display("FAIL vga_clr_addr: got=%b wr=%b addr=%h required wr=0 addr=000000", got, wr, addr);
    end
  endtask

  task automatic test_wrap_and_stall();
    bit got; int waits; logic wr, rg, wg; logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] exp;
    apply_reset();
    iWr_Req = 1'b1;
    for (int k = 0; k < FW / BURST + 2; k++) begin
      exp = BANK1 | ADDR_W'((k * BURST) % FW);
      do_burst(1, k == FW / BURST + 1, got, waits, wr, addr, rg, wg);
      vectors++;
      if ({got, wr, addr} !== {1'b1, 1'b1, exp}) begin
        miscompares++;
        $display("FAIL wrap_burst %0d: got=%b wr=%b addr=%h required wr=1 addr=%h", k, got, wr, addr, exp);
      end
    end
    iCam_FrameDone = 1'b1;
    @(negedge iCLK);
    iCam_FrameDone = 1'b0;
    vectors++;
    if (oWr_Stall !== 1'b1) begin miscompares++; $display("FAIL stall_set: stall=%b required 1", oWr_Stall); end
    iWr_Req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge iCLK);
      vectors++;
      if ({oCmd_Valid, oWr_Grant, oWr_Stall} !== 3'b001) begin
        miscompares++;
        $display("FAIL stall_block %0d: valid=%b wg=%b stall=%b required 0 0 1", i, oCmd_Valid, oWr_Grant, oWr_Stall);
      end
    end
    iWr_Req = 1'b0;
  endtask

  // Continues from the stalled state left by test_wrap_and_stall.
  task automatic test_swap_in_busy();
    bit got; int waits; logic wr, rg, wg; logic [ADDR_W-1:0] addr;
    iRd_Req = 1'b1;
    waits = 0;
    while (oCmd_Valid !== 1'b1 && waits < 20) begin @(negedge iCLK); waits++; end
    vectors++;
    if ({oCmd_Valid, oCmd_Write, oCmd_Addr} !== {1'b1, 1'b0, 22'h000000}) begin
      miscompares++;
      $display("FAIL swap_rd_cmd: valid=%b wr=%b addr=%h required 1 0 000000", oCmd_Valid, oCmd_Write, oCmd_Addr);
    end
    iRd_Req = 1'b0;
    @(negedge iCLK);
    iVga_FrameDone = 1'b1;
    @(negedge iCLK);
    iVga_FrameDone = 1'b0;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if ({oRd_Bank, oWr_Stall} !== 2'b01) begin
        miscompares++;
        $display("FAIL swap_busy_hold %0d: bank=%b stall=%b required 0 1", i, oRd_Bank, oWr_Stall);
      end
      if (i == 0) @(negedge iCLK);
    end
    iBurst_Done = 1'b1;
    @(negedge iCLK);
    iBurst_Done = 1'b0;
    vectors++;
    if (oRd_Bank !== 1'b0) begin miscompares++; $display("FAIL swap_idle_entry: bank=%b required 0", oRd_Bank); end
    @(negedge iCLK);
    vectors++;
    if ({oRd_Bank, oWr_Stall} !== 2'b10) begin
      miscompares++;
      $display("FAIL swap_done: bank=%b stall=%b required 1 0", oRd_Bank, oWr_Stall);
    end
    iWr_Req = 1'b1;
    do_burst(1, 1'b1, got, waits, wr, addr, rg, wg);
    vectors++;
    if ({got, wr, addr} !== {1'b1, 1'b1, 22'h000000}) begin
      miscompares++;
      $display("FAIL swap_wr_addr: got=%b wr=%b addr=%h required wr=1 addr=000000", got, wr, addr);
    end
    iRd_Req = 1'b1;
    do_burst(1, 1'b1, got, waits, wr, addr, rg, wg);
    vectors++;
    if ({got, wr, addr} !== {1'b1, 1'b0, BANK1}) begin
      miscompares++;
      $display("FAIL swap_rd_addr: got=%b wr=%b addr=%h required wr=0 addr=%h", got, wr, addr, BANK1);
    end
  endtask

  task automatic test_simultaneous_done();
    bit got; int waits; logic wr, rg, wg; logic [ADDR_W-1:0] addr;
    apply_reset();
    iCam_FrameDone = 1'b1; iVga_FrameDone = 1'b1;
    @(negedge iCLK);
    iCam_FrameDone = 1'b0; iVga_FrameDone = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge iCLK);
      vectors++;
      if ({oRd_Bank, oWr_Stall} !== 2'b01) begin
        miscompares++;
        $display("FAIL simul_no_swap %0d: bank=%b stall=%b required 0 1", i, oRd_Bank, oWr_Stall);
      end
    end
    iVga_FrameDone = 1'b1;
    @(negedge iCLK);
    iVga_FrameDone = 1'b0;
    vectors++;
    if (oRd_Bank !== 1'b0) begin miscompares++; $display("FAIL simul_edge_latch: bank=%b required 0", oRd_Bank); end
    @(negedge iCLK);
    vectors++;
    if ({oRd_Bank, oWr_Stall} !== 2'b10) begin
      miscompares++;
      $display("FAIL simul_swap: bank=%b stall=%b required 1 0", oRd_Bank, oWr_Stall);
    end
    iWr_Req = 1'b1;
    do_burst(1, 1'b1, got, waits, wr, addr, rg, wg);
    vectors++;
    if ({got, wr, addr} !== {1'b1, 1'b1, 22'h000000}) begin
      miscompares++;
      $display("FAIL simul_wr_addr: got=%b wr=%b addr=%h required wr=1 addr=000000", got, wr, addr);
    end
  endtask

  initial begin
    test_reset();
    test_read_only();
    test_arbitration();
    test_cmd_hold();
    test_vga_clear_on_accept();
    test_wrap_and_stall();
    test_swap_in_busy();
    test_simultaneous_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
